pipe_hazard_ctrl: RTL and testbench



---
 rtl/pipe_hazard_ctrl.sv | 115 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: carries decoded control through ID/EX, EX/MEM, MEM/WB and
// resolves load-use, branch/jump redirect and SYSCALL drain-and-handshake hazards.
module pipe_hazard_ctrl #(
  parameter int CTRL_W = 10,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              id_valid,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              id_sys,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_wreg,
  input  logic              ex_branch_taken,
  input  logic              syscall_done,
  output logic              stall,
  output logic              flush_ifid,
  output logic              ex_valid,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [REG_W-1:0]  ex_wreg,
  output logic              mem_valid,
  output logic [CTRL_W-1:0] mem_ctrl,
  output logic [REG_W-1:0]  mem_wreg,
  output logic              wb_valid,
  output logic [CTRL_W-1:0] wb_ctrl,
  output logic [REG_W-1:0]  wb_wreg,
  output logic              syscall_req,
  output logic [1:0]        state
);

  // state | meaning
  // RUN   | normal issue
  // DRAIN | SYSCALL held in ID, bubbles issued until EX/MEM/WB are empty
  // CALL  | syscall_req raised, waiting for syscall_done
  // ILL   | unused encoding, recovers to RUN
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    CALL  = 2'd2,
    ILL   = 2'd3
  } state_t;

  localparam int B_MEMREAD = 7;
  localparam int B_BRANCH  = 5;
  localparam int B_JUMP    = 4;

  state_t            st_q, st_d;
  logic              br_flush, load_use, sys_go, bubble;
  logic [CTRL_W-1:0] id_ctrl_clean;

  assign br_flush = ex_valid & ex_ctrl[B_BRANCH] & ex_branch_taken;
  assign load_use = ex_valid & ex_ctrl[B_MEMREAD] & (ex_wreg != '0) & id_valid &
                    ((ex_wreg == id_rs) | (ex_wreg == id_rt));
  assign sys_go   = (st_q == RUN) & id_valid & id_sys & ~br_flush;

  assign stall      = ~br_flush & (load_use | sys_go | (st_q == DRAIN) |
                                   ((st_q == CALL) & ~syscall_done));
  assign flush_ifid = br_flush | (id_valid & id_ctrl[B_JUMP] & ~stall);
  assign bubble     = ~id_valid | id_sys | stall | br_flush;

  assign syscall_req = (st_q == CALL);
  assign state       = st_q;

  // The decoder leaves ALUSrc/ALUop as don't-care on jumps; pin them to zero.
  always_comb begin
    id_ctrl_clean = id_ctrl;
    if (id_ctrl[B_JUMP]) id_ctrl_clean[3:0] = '0;
  end

  // In DRAIN a bubble always enters EX, so once EX and MEM are empty the
  // stages are all empty right after this edge.
  always_comb begin
    st_d = st_q;
    case (st_q)
      RUN:     if (sys_go) st_d = DRAIN;
      DRAIN:   if (~ex_valid & ~mem_valid) st_d = CALL;
      CALL:    if (syscall_done) st_d = RUN;
      default: st_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      st_q      <= RUN;
      ex_valid  <= 1'b0;
      ex_ctrl   <= '0;
      ex_wreg   <= '0;
      mem_valid <= 1'b0;
      mem_ctrl  <= '0;
      mem_wreg  <= '0;
      wb_valid  <= 1'b0;
      wb_ctrl   <= '0;
      wb_wreg   <= '0;
    end else begin
      st_q      <= st_d;
      wb_valid  <= mem_valid;
      wb_ctrl   <= mem_ctrl;
      wb_wreg   <= mem_wreg;
      mem_valid <= ex_valid;
      mem_ctrl  <= ex_ctrl;
      mem_wreg  <= ex_wreg;
      if (bubble) begin
        ex_valid <= 1'b0;
        ex_ctrl  <= '0;
        ex_wreg  <= '0;
      end else begin
        ex_valid <= 1'b1;
        ex_ctrl  <= id_ctrl_clean;
        ex_wreg  <= id_wreg;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios with constant expectations plus
// a randomized run checked against a stage-list reference model.
module tb_pipe_hazard_ctrl;
  localparam int CTRL_W = 10;
  localparam int REG_W  = 5;

  localparam logic [9:0] C_NOP  = 10'b0000000000;
  localparam logic [9:0] C_LW   = 10'b1110001000;
  localparam logic [9:0] C_ADD  = 10'b1000000010;
  localparam logic [9:0] C_ADDI = 10'b1000001000;
  localparam logic [9:0] C_BEQ  = 10'b0000100001;
  localparam logic [9:0] C_JCLN = 10'b0000010000;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  logic id_valid = 1'b0, id_sys = 1'b0, ex_branch_taken = 1'b0, syscall_done = 1'b0;
  logic [CTRL_W-1:0] id_ctrl = '0;
  logic [REG_W-1:0]  id_rs = '0, id_rt = '0, id_wreg = '0;
  logic stall, flush_ifid, syscall_req;
  logic ex_valid, mem_valid, wb_valid;
  logic [CTRL_W-1:0] ex_ctrl, mem_ctrl, wb_ctrl;
  logic [REG_W-1:0]  ex_wreg, mem_wreg, wb_wreg;
  logic [1:0] state;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.CTRL_W(CTRL_W), .REG_W(REG_W)) dut (
    .clk(clk), .rst_b(rst_b), .id_valid(id_valid), .id_ctrl(id_ctrl), .id_sys(id_sys),
    .id_rs(id_rs), .id_rt(id_rt), .id_wreg(id_wreg), .ex_branch_taken(ex_branch_taken),
    .syscall_done(syscall_done), .stall(stall), .flush_ifid(flush_ifid),
    .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_wreg(ex_wreg),
    .mem_valid(mem_valid), .mem_ctrl(mem_ctrl), .mem_wreg(mem_wreg),
    .wb_valid(wb_valid), .wb_ctrl(wb_ctrl), .wb_wreg(wb_wreg),
    .syscall_req(syscall_req), .state(state)
  );

  // Reference model: a list of three stage slots and a named sequencer phase.
  typedef struct packed {
    logic       v;
    logic [9:0] c;
    logic [4:0] w;
  } stage_t;

  localparam int PH_RUN = 0, PH_DRAIN = 1, PH_CALL = 2;
  stage_t m_ex = '0, m_mem = '0, m_wb = '0;
  int     m_phase = PH_RUN;
  logic   mu_hold, mu_redir, mu_start, mu_enter;

  function automatic logic m_redirect();
    return m_ex.v && m_ex.c[5] && ex_branch_taken;
  endfunction

  function automatic logic m_hazard();
    return m_ex.v && m_ex.c[7] && (m_ex.w != 0) && id_valid &&
           (m_ex.w == id_rs || m_ex.w == id_rt);
  endfunction

  function automatic logic m_sys_start();
    return (m_phase == PH_RUN) && id_valid && id_sys && !m_redirect();
  endfunction

  function automatic logic m_hold();
    if (m_redirect()) return 1'b0;
    if (m_phase == PH_DRAIN) return 1'b1;
    if (m_phase == PH_CALL) return !syscall_done;
    return m_hazard() || m_sys_start();
  endfunction

  function automatic logic m_squash();
    return m_redirect() || (id_valid && id_ctrl[4] && !m_hold());
  endfunction

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      m_ex = '0; m_mem = '0; m_wb = '0;
      m_phase = PH_RUN;
    end else begin
      mu_hold  = m_hold();
      mu_redir = m_redirect();
      mu_start = m_sys_start();
      mu_enter = id_valid && !id_sys && !mu_hold && !mu_redir;
      m_wb  = m_mem;
      m_mem = m_ex;
      if (mu_enter) begin
        m_ex.v = 1'b1;
        m_ex.c = id_ctrl;
        if (id_ctrl[4]) m_ex.c[3:0] = 4'b0000;
        m_ex.w = id_wreg;
      end else begin
        m_ex = '0;
      end
      // Phase changes: drain ends on the edge that leaves every stage empty.
      if (m_phase == PH_RUN && mu_start) m_phase = PH_DRAIN;
      else if (m_phase == PH_DRAIN && !m_ex.v && !m_mem.v && !m_wb.v) m_phase = PH_CALL;
      else if (m_phase == PH_CALL && syscall_done) m_phase = PH_RUN;
    end
  end

  task automatic drive(input logic v, input logic [9:0] c, input logic sys,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] wr,
                       input logic tk, input logic dn);
    @(negedge clk);
    id_valid = v; id_ctrl = c; id_sys = sys; id_rs = rs; id_rt = rt; id_wreg = wr;
    ex_branch_taken = tk; syscall_done = dn;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, C_NOP, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    n_cmp++; if ({ex_valid, mem_valid, wb_valid} !== 3'b000) begin n_err++;
      $display("FAIL rst_valids: got %b want 000", {ex_valid, mem_valid, wb_valid}); end
    n_cmp++; if ({ex_ctrl, mem_ctrl, wb_ctrl, ex_wreg, mem_wreg, wb_wreg} !== '0) begin n_err++;
      $display("FAIL rst_fields: got %h %h %h want 0", ex_ctrl, mem_ctrl, wb_ctrl); end
    n_cmp++; if (state !== 2'd0 || syscall_req !== 1'b0 || stall !== 1'b0 || flush_ifid !== 1'b0) begin n_err++;
      $display("FAIL rst_ctl: state %0d req %b stall %b flush %b want 0 0 0 0", state, syscall_req, stall, flush_ifid); end
    rst_b = 1'b1;
    drive(1'b1, C_ADD, 1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
    idle();
    n_cmp++; if (ex_valid !== 1'b1) begin n_err++;
      $display("FAIL rst_pre_valid: got %b want 1", ex_valid); end
    #2 rst_b = 1'b0;
    #1;
    n_cmp++; if (ex_valid !== 1'b0 || ex_ctrl !== '0 || ex_wreg !== '0) begin n_err++;
      $display("FAIL rst_async: ex_valid %b ctrl %h wreg %0d want 0", ex_valid, ex_ctrl, ex_wreg); end
    @(negedge clk);
    rst_b = 1'b1;
  endtask

  task automatic test_propagation();
    idle();
    drive(1'b1, C_ADDI, 1'b0, 5'd4, 5'd0, 5'd7, 1'b0, 1'b0);
    idle();
    n_cmp++; if ({ex_valid, ex_ctrl, ex_wreg} !== {1'b1, C_ADDI, 5'd7}) begin n_err++;
      $display("FAIL prop_ex: got %b %h %0d want 1 %h 7", ex_valid, ex_ctrl, ex_wreg, C_ADDI); end
    idle();
    n_cmp++; if ({mem_valid, mem_ctrl, mem_wreg} !== {1'b1, C_ADDI, 5'd7}) begin n_err++;
      $display("FAIL prop_mem: got %b %h %0d want 1 %h 7", mem_valid, mem_ctrl, mem_wreg, C_ADDI); end
    idle();
    n_cmp++; if ({wb_valid, wb_ctrl, wb_wreg} !== {1'b1, C_ADDI, 5'd7}) begin n_err++;
      $display("FAIL prop_wb: got %b %h %0d want 1 %h 7", wb_valid, wb_ctrl, wb_wreg, C_ADDI); end
  endtask

  task automatic test_load_use();
    idle();
    drive(1'b1, C_LW, 1'b0, 5'd1, 5'd2, 5'd8, 1'b0, 1'b0);
    n_cmp++; if (stall !== 1'b0) begin n_err++;
      $display("FAIL lu_pre: stall %b want 0", stall); end
    drive(1'b1, C_ADD, 1'b0, 5'd8, 5'd3, 5'd9, 1'b0, 1'b0);
    n_cmp++; if (stall !== 1'b1 || flush_ifid !== 1'b0 || ex_wreg !== 5'd8) begin n_err++;
      $display("FAIL lu_stall: stall %b flush %b ex_wreg %0d want 1 0 8", stall, flush_ifid, ex_wreg); end
    drive(1'b1, C_ADD, 1'b0, 5'd8, 5'd3, 5'd9, 1'b0, 1'b0);
    n_cmp++; if (stall !== 1'b0 || ex_valid !== 1'b0) begin n_err++;
      $display("FAIL lu_bubble: stall %b ex_valid %b want 0 0", stall, ex_valid); end
    idle();
    n_cmp++; if ({ex_valid, ex_ctrl, ex_wreg} !== {1'b1, C_ADD, 5'd9} || wb_wreg !== 5'd8) begin n_err++;
      $display("FAIL lu_issue: got %b %h %0d wb_wreg %0d want 1 %h 9 8", ex_valid, ex_ctrl, ex_wreg, wb_wreg, C_ADD); end
    drive(1'b1, C_LW, 1'b0, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0);
    drive(1'b1, C_ADD, 1'b0, 5'd0, 5'd3, 5'd9, 1'b0, 1'b0);
    n_cmp++; if (stall !== 1'b0) begin n_err++;
      $display("FAIL lu_r0: stall %b want 0", stall); end
    idle();
    n_cmp++; if (ex_valid !== 1'b1 || ex_ctrl !== C_ADD) begin n_err++;
      $display("FAIL lu_r0_issue: got %b %h want 1 %h", ex_valid, ex_ctrl, C_ADD); end
  endtask

  task automatic test_branch();
    idle();
    drive(1'b1, C_BEQ, 1'b0, 5'd3, 5'd4, 5'd0, 1'b0, 1'b0);
    drive(1'b1, C_ADDI, 1'b0, 5'd1, 5'd0, 5'd6, 1'b1, 1'b0);
    n_cmp++; if (flush_ifid !== 1'b1 || stall !== 1'b0) begin n_err++;
      $display("FAIL br_taken: flush %b stall %b want 1 0", flush_ifid, stall); end
    idle();
    n_cmp++; if (ex_valid !== 1'b0 || mem_ctrl !== C_BEQ) begin n_err++;
      $display("FAIL br_squash: ex_valid %b mem_ctrl %h want 0 %h", ex_valid, mem_ctrl, C_BEQ); end
    drive(1'b1, C_BEQ, 1'b0, 5'd3, 5'd4, 5'd0, 1'b0, 1'b0);
    drive(1'b1, C_ADDI, 1'b0, 5'd1, 5'd0, 5'd6, 1'b0, 1'b0);
    n_cmp++; if (flush_ifid !== 1'b0 || stall !== 1'b0) begin n_err++;
      $display("FAIL br_not_taken: flush %b stall %b want 0 0", flush_ifid, stall); end
    idle();
    n_cmp++; if (ex_valid !== 1'b1 || ex_ctrl !== C_ADDI) begin n_err++;
      $display("FAIL br_nt_issue: got %b %h want 1 %h", ex_valid, ex_ctrl, C_ADDI); end
  endtask

  task automatic test_jump();
    logic [9:0] jx;
    jx = 10'b0000010xxx;
    idle();
    drive(1'b1, jx, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    n_cmp++; if (flush_ifid !== 1'b1 || stall !== 1'b0) begin n_err++;
      $display("FAIL jmp_flush: flush %b stall %b want 1 0", flush_ifid, stall); end
    idle();
    n_cmp++; if (ex_valid !== 1'b1 || ex_ctrl !== C_JCLN || $isunknown(ex_ctrl)) begin n_err++;
      $display("FAIL jmp_ctrl: got %b %b want 1 %b", ex_valid, ex_ctrl, C_JCLN); end
    drive(1'b1, C_LW, 1'b0, 5'd1, 5'd2, 5'd5, 1'b0, 1'b0);
    drive(1'b1, 10'b0000011111, 1'b0, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0);
    n_cmp++; if (stall !== 1'b1 || flush_ifid !== 1'b0) begin n_err++;
      $display("FAIL jmp_lu_stall: stall %b flush %b want 1 0", stall, flush_ifid); end
    drive(1'b1, 10'b0000011111, 1'b0, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0);
    n_cmp++; if (stall !== 1'b0 || flush_ifid !== 1'b1) begin n_err++;
      $display("FAIL jmp_lu_release: stall %b flush %b want 0 1", stall, flush_ifid); end
    idle();
    n_cmp++; if (ex_ctrl !== C_JCLN) begin n_err++;
      $display("FAIL jmp_sanitise: got %b want %b", ex_ctrl, C_JCLN); end
  endtask

  task automatic test_syscall();
    idle();
    for (int i = 0; i < 3; i++) drive(1'b1, C_ADD, 1'b0, 5'd1, 5'd2, 5'(10 + i), 1'b0, 1'b0);
    drive(1'b1, C_NOP, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    n_cmp++; if (state !== 2'd0 || stall !== 1'b1 || {ex_valid, mem_valid, wb_valid} !== 3'b111) begin n_err++;
      $display("FAIL sys_seen: state %0d stall %b valids %b want 0 1 111", state, stall, {ex_valid, mem_valid, wb_valid}); end
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, C_NOP, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      n_cmp++; if (state !== 2'd1 || stall !== 1'b1 || syscall_req !== 1'b0) begin n_err++;
        $display("FAIL sys_drain[%0d]: state %0d stall %b req %b want 1 1 0", i, state, stall, syscall_req); end
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, C_NOP, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      n_cmp++; if (state !== 2'd2 || syscall_req !== 1'b1 || stall !== 1'b1 ||
                   {ex_valid, mem_valid, wb_valid} !== 3'b000) begin n_err++;
        $display("FAIL sys_call[%0d]: state %0d req %b stall %b valids %b want 2 1 1 000", i, state, syscall_req, stall,
                 {ex_valid, mem_valid, wb_valid}); end
    end
    drive(1'b1, C_NOP, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    n_cmp++; if (state !== 2'd2 || stall !== 1'b0) begin n_err++;
      $display("FAIL sys_done: state %0d stall %b want 2 0", state, stall); end
    idle();
    n_cmp++; if (state !== 2'd0 || syscall_req !== 1'b0 || ex_valid !== 1'b0) begin n_err++;
      $display("FAIL sys_exit: state %0d req %b ex_valid %b want 0 0 0", state, syscall_req, ex_valid); end
  endtask

  task automatic test_conflict();
    idle();
    drive(1'b1, C_BEQ, 1'b0, 5'd3, 5'd4, 5'd0, 1'b0, 1'b0);
    drive(1'b1, C_NOP, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    n_cmp++; if (stall !== 1'b0 || flush_ifid !== 1'b1 || state !== 2'd0) begin n_err++;
      $display("FAIL cfl_now: stall %b flush %b state %0d want 0 1 0", stall, flush_ifid, state); end
    for (int i = 0; i < 2; i++) begin
      idle();
      n_cmp++; if (state !== 2'd0 || syscall_req !== 1'b0 || ex_valid !== 1'b0) begin n_err++;
        $display("FAIL cfl_after[%0d]: state %0d req %b ex_valid %b want 0 0 0", i, state, syscall_req, ex_valid); end
    end
  endtask

  task automatic test_reset_in_call();
    idle();
    drive(1'b1, C_NOP, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < 10 && state !== 2'd2; i++)
      drive(1'b1, C_NOP, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    n_cmp++; if (state !== 2'd2) begin n_err++;
      $display("FAIL rcall_reach: state %0d want 2 within 10 cycles", state); end
    #2 rst_b = 1'b0;
    #1;
    n_cmp++; if (state !== 2'd0 || syscall_req !== 1'b0) begin n_err++;
      $display("FAIL rcall_clear: state %0d req %b want 0 0", state, syscall_req); end
    @(negedge clk);
    rst_b = 1'b1;
    idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) != 0, 10'($urandom), $urandom_range(0, 19) == 0,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
      n_cmp++; if (stall !== m_hold() || flush_ifid !== m_squash()) begin n_err++;
        $display("FAIL rnd_hazard[%0d]: stall %b flush %b want %b %b", i, stall, flush_ifid, m_hold(), m_squash()); end
      n_cmp++; if (state !== 2'(m_phase) || syscall_req !== (m_phase == PH_CALL)) begin n_err++;
        $display("FAIL rnd_fsm[%0d]: state %0d req %b want %0d %b", i, state, syscall_req, m_phase, m_phase == PH_CALL); end
      n_cmp++; if ({ex_valid, ex_ctrl, ex_wreg} !== m_ex) begin n_err++;
        $display("FAIL rnd_ex[%0d]: got %h want %h", i, {ex_valid, ex_ctrl, ex_wreg}, m_ex); end
      n_cmp++; if ({mem_valid, mem_ctrl, mem_wreg} !== m_mem) begin n_err++;
        $display("FAIL rnd_mem[%0d]: got %h want %h", i, {mem_valid, mem_ctrl, mem_wreg}, m_mem); end
      n_cmp++; if ({wb_valid, wb_ctrl, wb_wreg} !== m_wb) begin n_err++;
        $display("FAIL rnd_wb[%0d]: got %h want %h", i, {wb_valid, wb_ctrl, wb_wreg}, m_wb); end
    end
  endtask

  initial begin
    test_reset();
    test_propagation();
    test_load_use();
    test_branch();
    test_jump();
    test_syscall();
    test_conflict();
    test_reset_in_call();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
